doorway_beam_generator: RTL
===========================

# doorway_beam_generator

Generates the two-photocell beam waveform a person produces when walking through a doorway. It drives `wej` (outer beam) and `wyj` (inner beam) from queued entry/exit commands with a programmable per-phase dwell. It is the transmit-side counterpart of the doorway people counter. It is used as an on-chip sensor emulator for self-test and for driving the counter in simulation and on the board.

## Interface
Parameters:
- `DWELL_W`, 8 — width of the dwell field, in cycles per phase.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  generator idle; command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_dir`  in  1  0 = entry, 1 = exit; sampled at accept.
- `cmd_balk`  in  1  balk (turn-back) passage; sampled at accept; see Configuration.
- `dwell`  in  `DWELL_W`  cycles per phase; sampled at accept; 0 is treated as 1.
- `wej`  out  1  outer beam, 1 = unbroken; registered.
- `wyj`  out  1  inner beam, 1 = unbroken; registered.
- `busy`  out  1  passage in progress (state != IDLE).
- `done`  out  1  one-cycle pulse when a passage finishes.
- `ent_cnt`  out  8  completed entries, wraps 255→0.
- `ext_cnt`  out  8  completed exits, wraps 255→0.

## Operation
- States: IDLE, PA, PB, PC, GAP. `cmd_ready = (state == IDLE)`.
- Beam pattern `{wej,wyj}` per state:
  - Entry: PA = 01, PB = 00, PC = 10, GAP = 11.
  - Exit: PA = 10, PB = 00, PC = 01, GAP = 11.
  - IDLE: 11.
- Accept: latch `cmd_dir`, `cmd_balk`, and `D = max(dwell,1)`. Go to PA and load the phase counter with D-1.
- Each of PA, PB, PC, GAP lasts exactly D cycles. The phase counter decrements each cycle. At 0 it advances: PA→PB→PC→GAP→IDLE.
- On GAP→IDLE:
  - `done` = 1 for one cycle.
  - Increment `ent_cnt` (entry) or `ext_cnt` (exit) unless the passage was a balk.
- Inputs other than `nrst` are ignored while busy. Changes to `dwell` or `cmd_dir` mid-passage have no effect.
- Only one of `wej`/`wyj` changes per transition, so the waveform is Gray-sequenced with no glitch states.
- Counters are 8-bit modulo. 255 + 1 = 0, and no flag is raised.

## Timing
- Reset values: state IDLE, `wej`=1, `wyj`=1, `cmd_ready`=1, `busy`=0, `done`=0, `ent_cnt`=0, `ext_cnt`=0.
- Accept at edge k:
  - Phase A pattern is visible from edge k.
  - PB from k+D, PC from k+2D, 11 from k+3D.
  - IDLE and `done`=1 from k+4D for one cycle. The counter is updated at the same edge.
- `cmd_ready` rises at k+4D. The earliest next accept is edge k+4D+1, so the back-to-back passage period is 4D+1 cycles.
- `cmd_valid` held high while busy is not accepted until IDLE; there is no queueing.
- `nrst` asserted mid-passage: outputs go to 11 immediately (asynchronous), counters clear, the command is lost, and no `done` is produced.
- With D = 2^`DWELL_W`-1 the passage takes 4·D cycles, with no overflow of the phase counter.

## Configuration
- Macro `DOORWAY_GEN_BALK_EN`.
- Defined: `cmd_balk`=1 produces a turn-back sequence.
  - Entry balk: 01, 00, 01, 11 (GAP). Exit balk: 10, 00, 10, 11.
  - Each phase lasts D cycles and `done` pulses normally.
  - Neither counter increments.
- Not defined: the `cmd_balk` port remains but is ignored (treated as 0). Every command is a full passage.

## Test plan
- Reset then idle 10 cycles → `{wej,wyj}`=11, `cmd_ready`=1, `done`=0, both counters 0.
- Entry with `dwell`=3 accepted at edge k:
  - `{wej,wyj}` = 01 for k..k+2, 00 for k+3..k+5, 10 for k+6..k+8, 11 from k+9.
  - `done` high during the cycle after edge k+12 only; `ent_cnt`=1.
- Exit with `dwell`=0 → behaves as D=1: pattern 10, 00, 01, 11 one cycle each; `ext_cnt`=1; next accept no earlier than 5 cycles after the first.
- 256 entries back-to-back with `cmd_valid` held high → `ent_cnt` wraps to 0; `done` pulses exactly 256 times; no command accepted while `busy`.
- `nrst` low during PB of an entry → `{wej,wyj}`=11 immediately, counters 0, no `done`; a new command after reset runs normally.
- With `DOORWAY_GEN_BALK_EN`, entry balk with `dwell`=2 → 01, 01, 00, 00, 01, 01, 11, 11; `done` pulses; `ent_cnt` unchanged. Without the macro, the same stimulus → a normal entry with `ent_cnt`+1.

Source files
------------

// File: rtl/doorway_beam_generator.sv
// doorway_beam_generator
//
// Emulates the two-photocell waveform a person produces when walking through
// a doorway. Each accepted command plays four phases (PA, PB, PC, GAP) of D
// cycles each on the outer (wej) and inner (wyj) beams, where D = max(dwell,1).
// Beams idle high (unbroken). Used as an on-chip sensor emulator for self-test
// and for driving the people counter.
//
// Ports:
//   clk        clock, rising edge
//   nrst       asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  generator idle, command accepted on cmd_valid && cmd_ready
//   cmd_dir    0 = entry, 1 = exit (sampled at accept)
//   cmd_balk   turn-back passage (sampled at accept, only honoured with the
//              optional feature enabled)
//   dwell      cycles per phase, 0 treated as 1 (sampled at accept)
//   wej, wyj   outer / inner beam, 1 = unbroken, registered
//   busy       passage in progress
//   done       one-cycle pulse when a passage finishes
//   ent_cnt    completed entries, modulo 256
//   ext_cnt    completed exits, modulo 256
//
// Optional feature macro: DOORWAY_GEN_BALK_EN
//   defined     : cmd_balk = 1 plays a turn-back sequence (PC repeats PA's
//                 pattern) and does not bump either counter
//   not defined : cmd_balk is ignored, every command is a full passage
//
// States:
//   state | meaning
//   IDLE  | beams 11, cmd_ready high, waiting for a command
//   PA    | first beam broken (entry: outer, exit: inner)
//   PB    | both beams broken
//   PC    | second beam only (or first beam again on a balk)
//   GAP   | both beams clear, spacing before the next passage

module doorway_beam_generator #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic               cmd_balk,
  input  logic [DWELL_W-1:0] dwell,
  output logic               wej,
  output logic               wyj,
  output logic               busy,
  output logic               done,
  output logic [7:0]         ent_cnt,
  output logic [7:0]         ext_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PA   = 3'd1,
    PB   = 3'd2,
    PC   = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_ZERO = '0;
  localparam logic [7:0]         CNT_ONE    = 8'd1;

  state_t             state;
  logic [DWELL_W-1:0] phase_cnt;
  logic [DWELL_W-1:0] dwell_m1;
  logic               dir_q;
  logic               balk_q;
  logic               balk_in;
  logic [DWELL_W-1:0] dwell_in_m1;

`ifdef DOORWAY_GEN_BALK_EN
  assign balk_in = cmd_balk;
`else
  logic unused_balk;
  assign unused_balk = cmd_balk;
  assign balk_in     = 1'b0;
`endif

  // Phase length minus one; dwell of 0 behaves as 1, so both load 0.
  assign dwell_in_m1 = (dwell == DWELL_ZERO) ? DWELL_ZERO : (dwell - DWELL_ONE);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Beam pattern {wej,wyj} shown while in state s. Consecutive patterns of a
  // sequence differ in one bit only, so the beams never glitch through 00/11.
  function automatic logic [1:0] beam_pat(input state_t s, input logic dir,
                                          input logic balk);
    logic [1:0] p;
    case (s)
      PA:      p = dir ? 2'b10 : 2'b01;
      PB:      p = 2'b00;
      PC:      p = balk ? (dir ? 2'b10 : 2'b01) : (dir ? 2'b01 : 2'b10);
      default: p = 2'b11;
    endcase
    return p;
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      PA:      n = PB;
      PB:      n = PC;
      PC:      n = GAP;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      dwell_m1  <= '0;
      dir_q     <= 1'b0;
      balk_q    <= 1'b0;
      wej       <= 1'b1;
      wyj       <= 1'b1;
      done      <= 1'b0;
      ent_cnt   <= '0;
      ext_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state      <= PA;
            phase_cnt  <= dwell_in_m1;
            dwell_m1   <= dwell_in_m1;
            dir_q      <= cmd_dir;
            balk_q     <= balk_in;
            {wej, wyj} <= beam_pat(PA, cmd_dir, balk_in);
          end
        end
        default: begin
          // Every phase holds for dwell_m1+1 cycles: the counter is loaded
          // with D-1 and the phase advances on the edge where it reads 0.
          if (phase_cnt != DWELL_ZERO) begin
            phase_cnt <= phase_cnt - DWELL_ONE;
          end else begin
            state      <= next_phase(state);
            phase_cnt  <= dwell_m1;
            {wej, wyj} <= beam_pat(next_phase(state), dir_q, balk_q);
            if (state == GAP) begin
              done <= 1'b1;
              if (!balk_q) begin
                if (dir_q) ext_cnt <= ext_cnt + CNT_ONE;
                else       ent_cnt <= ent_cnt + CNT_ONE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
